root_seq_ctrl: RTL and testbench

ROOT_SEQ_CTRL -- requirements
Module: root_seq_ctrl

---
 rtl/root_seq_ctrl.sv | 151 +++++++++++++++
 tb/tb_root_seq_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/root_seq_ctrl.sv
// Root sequencer: launches enabled children one at a time in index
// order, waits for each to finish, and reports timeout or abort.
module root_seq_ctrl #(
    parameter int N_CHILD = 5,
    parameter int TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic [N_CHILD-1:0] enable_mask_i,
    input  logic               abort_i,
    input  logic [N_CHILD-1:0] child_done_i,
    output logic [N_CHILD-1:0] child_start_o,
    output logic [2:0]         cur_idx_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic [2:0]         err_idx_o
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_FINISH
    } state_t;

    localparam logic [7:0]         TMAX = 8'(TIMEOUT);
    localparam logic [N_CHILD-1:0] ONE  = N_CHILD'(1);

    state_t             state_q, state_d;
    logic [N_CHILD-1:0] mask_q, mask_d;
    logic [7:0]         timer_q, timer_d;
    logic [2:0]         idx_q, idx_d;
    logic               err_q, err_d;
    logic [2:0]         eidx_q, eidx_d;
    logic [N_CHILD-1:0] start_d;
    logic [3:0]         sel;

    // Lowest set bit of m at or above lo; bit 3 flags "found".
    function automatic logic [3:0] pick(
        input logic [N_CHILD-1:0] m,
        input int                 lo
    );
        logic [3:0] r;
        r = '0;
        for (int i = N_CHILD - 1; i >= 0; i--) begin
            if (m[i] && i >= lo) begin
                r = {1'b1, 3'(i)};
            end
        end
        return r;
    endfunction

    // Next-state, bookkeeping and start-pulse selection.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        err_d   = err_q;
        eidx_d  = eidx_q;
        start_d = '0;
        sel     = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    mask_d = enable_mask_i;
                    err_d  = 1'b0;
                    eidx_d = '0;
                    sel    = pick(enable_mask_i, 0);
                    if (sel[3]) begin
                        idx_d   = sel[2:0];
                        start_d = ONE << sel[2:0];
                        state_d = S_LAUNCH;
                    end else begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_LAUNCH: begin
                timer_d = '0;
                if (abort_i) begin
                    err_d   = 1'b1;
                    eidx_d  = idx_q;
                    state_d = S_FINISH;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (abort_i) begin
                    err_d   = 1'b1;
                    eidx_d  = idx_q;
                    state_d = S_FINISH;
                end else if (child_done_i[idx_q]) begin
                    sel = pick(mask_q, int'(idx_q) + 1);
                    if (sel[3]) begin
                        idx_d   = sel[2:0];
                        start_d = ONE << sel[2:0];
                        state_d = S_LAUNCH;
                    end else begin
                        state_d = S_FINISH;
                    end
                end else if (timer_q == TMAX) begin
                    err_d   = 1'b1;
                    eidx_d  = idx_q;
                    state_d = S_FINISH;
                end else begin
                    timer_d = (timer_q < TMAX) ? timer_q + 8'd1 : TMAX;
                end
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            mask_q        <= '0;
            timer_q       <= '0;
            idx_q         <= '0;
            err_q         <= 1'b0;
            eidx_q        <= '0;
            child_start_o <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
        end else begin
            state_q       <= state_d;
            mask_q        <= mask_d;
            timer_q       <= timer_d;
            idx_q         <= idx_d;
            err_q         <= err_d;
            eidx_q        <= eidx_d;
            child_start_o <= start_d;
            busy_o        <= (state_d != S_IDLE);
            done_o        <= (state_d == S_FINISH);
        end
    end

    assign cur_idx_o = idx_q;
    assign err_o     = err_q;
    assign err_idx_o = eidx_q;

endmodule

// File: tb/tb_root_seq_ctrl.sv
// Bench for root_seq_ctrl: directed vector table, randomized passes
// against a pass-level schedule model, and a reset sequence.
module tb_root_seq_ctrl;

    localparam int N    = 5;
    localparam int TMO  = 4;
    localparam int MAXC = 64;

    logic           clk = 1'b0;
    logic           rst;
    logic           start_i;
    logic [N-1:0]   enable_mask_i;
    logic           abort_i;
    logic [N-1:0]   child_done_i;
    logic [N-1:0]   child_start_o;
    logic [2:0]     cur_idx_o;
    logic           busy_o;
    logic           done_o;
    logic           err_o;
    logic [2:0]     err_idx_o;

    root_seq_ctrl #(.N_CHILD(N), .TIMEOUT(TMO)) dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .enable_mask_i (enable_mask_i),
        .abort_i       (abort_i),
        .child_done_i  (child_done_i),
        .child_start_o (child_start_o),
        .cur_idx_o     (cur_idx_o),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .err_idx_o     (err_idx_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Pass schedule predicted by the model, indexed by cycle.
    logic [N-1:0] m_start [MAXC];
    logic [N-1:0] m_resp  [MAXC];
    int           m_await [MAXC];
    int           m_cur   [MAXC];
    int           m_done;
    int           m_eidx;
    int           m_hold = 0;
    bit           m_err;
    int           lat_a   [N];

    int o_done, o_nd, o_order, o_eidx;
    bit o_err;

    typedef struct packed {
        logic [4:0]  mask;
        logic [19:0] lat;
        logic [7:0]  ab;
        logic [4:0]  noise;
        logic [7:0]  done_c;
        logic        err;
        logic [2:0]  eidx;
        logic [19:0] order;
    } vec_t;

    vec_t vt [11];

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " start"}, int'(child_start_o), 0);
        chk({tag, " busy"}, int'(busy_o), 0);
        chk({tag, " done"}, int'(done_o), 0);
        chk({tag, " err"}, int'(err_o), 0);
        chk({tag, " eidx"}, int'(err_idx_o), 0);
        chk({tag, " cur"}, int'(cur_idx_o), 0);
    endtask

    // Each child occupies one launch cycle t followed by wait cycles up
    // to its response (t+lat) or, if it never answers, t+1+TMO.
    task automatic model_pass(input logic [N-1:0] mask, input int a);
        int t, e, cur;
        bit resp;
        for (int c = 0; c < MAXC; c++) begin
            m_start[c] = '0;
            m_resp[c]  = '0;
            m_await[c] = -1;
            m_cur[c]   = -1;
        end
        t = 1; m_done = -1; m_err = 0; m_eidx = 0; cur = m_hold;
        for (int i = 0; i < N; i++) begin
            if (mask[i] && m_done < 0) begin
                m_start[t] = N'(1 << i);
                m_cur[t] = i;
                cur = i;
                resp = (lat_a[i] <= TMO + 1);
                e = resp ? t + lat_a[i] : t + 1 + TMO;
                for (int c = t + 1; c <= e; c++) begin
                    m_await[c] = i;
                    m_cur[c] = i;
                end
                if (resp) m_resp[e] |= N'(1 << i);
                if (a >= t && a <= e) begin
                    m_err = 1; m_eidx = i; m_done = a + 1;
                end else if (resp) begin
                    t = e + 1;
                end else begin
                    m_err = 1; m_eidx = i; m_done = e + 1;
                end
            end
        end
        if (m_done < 0) m_done = t;
        m_hold = cur;
    endtask

    task automatic run_pass(input logic [N-1:0] mask, input logic [19:0] lat,
                            input int a, input logic [N-1:0] fixn, input bit rnd);
        int cur_run;
        logic [N-1:0] nz;
        string tg;
        for (int i = 0; i < N; i++) lat_a[i] = int'(lat[4*i +: 4]);
        cur_run = m_hold;
        model_pass(mask, a);
        o_done = -1; o_nd = 0; o_order = 0; o_err = 0; o_eidx = 0;
        start_i = 1'b1;
        enable_mask_i = mask;
        abort_i = 1'b0;
        child_done_i = rnd ? N'($urandom) : fixn;
        for (int c = 1; c <= m_done + 1; c++) begin
            @(posedge clk); #1;
            nz = rnd ? N'($urandom) : fixn;
            if (m_await[c] >= 0) nz &= ~N'(1 << m_await[c]);
            child_done_i = nz | m_resp[c];
            start_i = (rnd && c <= m_done) ? 1'($urandom) : 1'b0;
            enable_mask_i = rnd ? N'($urandom) : mask;
            abort_i = (c == a) || (rnd && c >= m_done && $urandom_range(0, 1) == 1);
            @(negedge clk);
            if (m_cur[c] >= 0) cur_run = m_cur[c];
            tg = $sformatf("c%0d", c);
            chk({tg, " start"}, int'(child_start_o), int'(m_start[c]));
            chk({tg, " busy"}, int'(busy_o), (c <= m_done) ? 1 : 0);
            chk({tg, " done"}, int'(done_o), (c == m_done) ? 1 : 0);
            chk({tg, " cur"}, int'(cur_idx_o), cur_run);
            chk({tg, " err"}, int'(err_o), (m_err && c >= m_done) ? 1 : 0);
            chk({tg, " eidx"}, int'(err_idx_o), (m_err && c >= m_done) ? m_eidx : 0);
            for (int i = 0; i < N; i++)
                if (child_start_o[i]) o_order = (o_order << 4) | (i + 1);
            if (done_o) begin
                o_nd++;
                if (o_done < 0) o_done = c;
            end
        end
        o_err = err_o;
        o_eidx = int'(err_idx_o);
        start_i = 1'b0;
        abort_i = 1'b0;
        child_done_i = '0;
    endtask

    initial begin
        //        mask      lat       ab  noise     done err eidx order
        vt[0]  = {5'b11111, 20'h33333, 8'd0, 5'b00000, 8'd21, 1'b0, 3'd0, 20'h12345};
        vt[1]  = {5'b10100, 20'h33333, 8'd0, 5'b00000, 8'd9,  1'b0, 3'd0, 20'h00035};
        vt[2]  = {5'b00000, 20'h33333, 8'd0, 5'b00000, 8'd1,  1'b0, 3'd0, 20'h00000};
        vt[3]  = {5'b11111, 20'h333F2, 8'd0, 5'b00000, 8'd10, 1'b1, 3'd1, 20'h00012};
        vt[4]  = {5'b01000, 20'hFFFFF, 8'd3, 5'b00000, 8'd4,  1'b1, 3'd3, 20'h00004};
        vt[5]  = {5'b00001, 20'h00001, 8'd0, 5'b00000, 8'd3,  1'b0, 3'd0, 20'h00001};
        vt[6]  = {5'b00100, 20'h00200, 8'd3, 5'b00000, 8'd4,  1'b1, 3'd2, 20'h00003};
        vt[7]  = {5'b00101, 20'h00401, 8'd0, 5'b00001, 8'd8,  1'b0, 3'd0, 20'h00013};
        vt[8]  = {5'b00110, 20'h33333, 8'd1, 5'b00000, 8'd2,  1'b1, 3'd1, 20'h00002};
        vt[9]  = {5'b00001, 20'h00005, 8'd0, 5'b00000, 8'd7,  1'b0, 3'd0, 20'h00001};
        vt[10] = {5'b00001, 20'h00006, 8'd0, 5'b00000, 8'd7,  1'b1, 3'd0, 20'h00001};

        rst = 1'b1;
        start_i = 1'b0;
        enable_mask_i = '0;
        abort_i = 1'b0;
        child_done_i = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 11; v++) begin
            run_pass(vt[v].mask, vt[v].lat, int'(vt[v].ab), vt[v].noise, 1'b0);
            chk($sformatf("v%0d done_cycle", v), o_done, int'(vt[v].done_c));
            chk($sformatf("v%0d done_count", v), o_nd, 1);
            chk($sformatf("v%0d order", v), o_order, int'(vt[v].order));
            chk($sformatf("v%0d err", v), int'(o_err), int'(vt[v].err));
            chk($sformatf("v%0d eidx", v), o_eidx, int'(vt[v].eidx));
        end

        for (int p = 0; p < 40; p++) begin
            logic [19:0] lr;
            int ab;
            for (int i = 0; i < N; i++) lr[4*i +: 4] = 4'($urandom_range(1, 7));
            ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 30) : 0;
            run_pass(N'($urandom), lr, ab, '0, 1'b1);
            chk($sformatf("r%0d done_count", p), o_nd, 1);
        end

        // Reset while waiting on child 2, with start held high.
        start_i = 1'b1;
        enable_mask_i = 5'b00100;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("pre_rst busy", int'(busy_o), 1);
        chk("pre_rst cur", int'(cur_idx_o), 2);
        @(posedge clk); #1;
        rst = 1'b1;
        start_i = 1'b1;
        enable_mask_i = 5'b00001;
        abort_i = 1'b1;
        @(negedge clk);
        chk("rst_cycle busy", int'(busy_o), 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk_zero("rst1");
        @(posedge clk); #1;
        @(negedge clk);
        chk_zero("rst2");
        @(posedge clk); #1;
        rst = 1'b0;
        abort_i = 1'b0;
        @(negedge clk);
        chk_zero("post_rst");
        @(posedge clk); #1;
        start_i = 1'b0;
        @(negedge clk);
        chk("post_rst pulse", int'(child_start_o), 1);
        chk("post_rst busy", int'(busy_o), 1);
        @(posedge clk); #1;
        child_done_i = 5'b00001;
        @(posedge clk); #1;
        child_done_i = '0;
        @(negedge clk);
        chk("post_rst done", int'(done_o), 1);
        chk("post_rst err", int'(err_o), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
